// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell,
// time-multiplexed LSB first under a three-state FSM.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sac_clk,
    input  logic             sac_rst_n,
    input  logic             sac_start,
    input  logic             sac_sub,
    input  logic             sac_cin,
    input  logic [WIDTH-1:0] sac_port_a,
    input  logic [WIDTH-1:0] sac_port_b,
    output logic             sac_busy,
    output logic             sac_done,
    output logic [WIDTH-1:0] sac_sum,
    output logic             sac_cout,
    output logic             sac_ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] res_next;

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign res_next = {cell_s, res_sr[WIDTH-1:1]};
    assign sac_busy = (state == RUN);
    assign sac_done = (state == DONE);

    always_ff @(posedge sac_clk or negedge sac_rst_n) begin
        if (!sac_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            sac_sum  <= '0;
            sac_cout <= 1'b0;
            sac_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sac_start) begin
                        // Subtract as A + ~B + 1
                        a_sr  <= sac_port_a;
                        b_sr  <= sac_sub ? ~sac_port_b : sac_port_b;
                        carry <= sac_sub ? 1'b1 : sac_cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= cell_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here
                        sac_sum  <= res_next;
                        sac_cout <= cell_co;
                        sac_ovf  <= carry ^ cell_co;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
// Linear sequence of steps with immediate-assertion checks.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .sac_clk    (clk),
        .sac_rst_n  (rst_n),
        .sac_start  (start),
        .sac_sub    (sub),
        .sac_cin    (cin),
        .sac_port_a (pa),
        .sac_port_b (pb),
        .sac_busy   (busy),
        .sac_done   (done),
        .sac_sum    (sum),
        .sac_cout   (cout),
        .sac_ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic c);
        @(negedge clk);
        pa = a; pb = b; sub = s; cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        chk("accept_busy", busy, 1);
    endtask

    // Accept edge is edge 0; done_edges counts edges 0..k inclusive.
    task automatic run_op(input string tag,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input int inject,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo);
        int busy_n, done_n, done_edges, both_n;
        busy_n = 1; done_n = 0; done_edges = -1; both_n = 0;
        start_op(a, b, s, c);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = (k == inject);
            pa = W'($urandom);
            pb = W'($urandom);
            sub = ~s;
            cin = ~c;
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (busy && done) both_n++;
            if (done) begin
                done_n++;
                if (done_edges < 0) done_edges = k + 1;
            end
        end
        start = 1'b0;
        chk({tag, "_done_edges"}, done_edges, W + 1);
        chk({tag, "_busy_cycles"}, busy_n, W);
        chk({tag, "_done_pulses"}, done_n, 1);
        chk({tag, "_busy_and_done"}, both_n, 0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc, ho;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0;
        pa = '0; pb = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add",  8'h5A, 8'h3C, 1'b0, 1'b0, 0, 8'h96, 1'b0, 1'b1);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_op("cin",  8'h7F, 8'h00, 1'b0, 1'b1, 0, 8'h80, 1'b0, 1'b1);
        run_op("sub1", 8'h10, 8'h20, 1'b1, 1'b1, 0, 8'hF0, 1'b0, 1'b0);
        run_op("sub2", 8'h20, 8'h10, 1'b1, 1'b0, 0, 8'h10, 1'b1, 1'b0);
        run_op("busy_start", 8'h33, 8'h11, 1'b0, 1'b0, 3,
               8'h44, 1'b0, 1'b0);

        // Reset during RUN cycle 4
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_ovf", ovf, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mid_rst_no_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0);

        // Results hold through IDLE while inputs wiggle
        hs = 8'h02; hc = 1'b0; ho = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            pa = W'($urandom);
            pb = W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_sum", sum, hs);
            chk("hold_cout", cout, hc);
            chk("hold_ovf", ovf, ho);
            chk("hold_busy", busy, 0);
            chk("hold_done", done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
